// File: rtl/kf_pkg.sv
// Shared types and sizes for the Kalman filter datapath storage stage.
// Contents: word/address/write-counter widths, databank FSM state enum,
// and a saturating-increment helper for the write counter.
package kf_pkg;

  localparam int unsigned KF_W       = 24;
  localparam int unsigned KF_ADDRW   = 5;
  localparam int unsigned KF_WRCNT_W = 16;

  typedef enum logic {
    SWEEP,
    RUN
  } kf_db_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [KF_WRCNT_W-1:0] kf_sat_inc(input logic [KF_WRCNT_W-1:0] v);
    return (v == '1) ? v : v + KF_WRCNT_W'(1);
  endfunction

endpackage

// File: rtl/kf_databank_if.sv
// Router-to-databank bus: write data, two read addresses, write strobe,
// clear request, plus the two read operands, busy flag and write count.
// Modports: master (router / producer side), slave (kf_databank).
interface kf_databank_if
  import kf_pkg::*;
#(
  parameter int unsigned W     = KF_W,
  parameter int unsigned ADDRW = KF_ADDRW
);

  logic [W-1:0]          db_data;
  logic [ADDRW-1:0]      db_dira;
  logic [ADDRW-1:0]      db_dirb;
  logic                  db_write;
  logic                  CLEAR;
  logic [W-1:0]          DOUT_A;
  logic [W-1:0]          DOUT_B;
  logic                  BUSY;
  logic [KF_WRCNT_W-1:0] WR_CNT;

  modport master (
    output db_data, db_dira, db_dirb, db_write, CLEAR,
    input  DOUT_A, DOUT_B, BUSY, WR_CNT
  );

  modport slave (
    input  db_data, db_dira, db_dirb, db_write, CLEAR,
    output DOUT_A, DOUT_B, BUSY, WR_CNT
  );

endinterface

// File: rtl/kf_clear_seq.sv
// Self-clearing sweep sequencer for the databank.
// After reset, or on a clear request while running, it walks every entry
// once, asking the top level to write zero there, then hands the array over.
// Ports: clk, rst (async, active-high), clear (sweep request),
//        busy (sweep in progress), sweep_we / sweep_addr (zeroing write port).
module kf_clear_seq
  import kf_pkg::*;
#(
  parameter int unsigned ADDRW = KF_ADDRW,
  parameter int unsigned DEPTH = 1 << ADDRW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic             busy,
  output logic             sweep_we,
  output logic [ADDRW-1:0] sweep_addr
);

  localparam logic [ADDRW-1:0] LAST = ADDRW'(DEPTH - 1);

  kf_db_state_t     state;
  logic [ADDRW-1:0] ptr;

  // Sweep/run state machine; a clear request during a sweep is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SWEEP;
      ptr   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        SWEEP: begin
          if (ptr == LAST) begin
            state <= RUN;
            ptr   <= '0;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + ADDRW'(1);
          end
        end
        RUN: begin
          if (clear) begin
            state <= SWEEP;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= SWEEP;
          ptr   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  assign sweep_we   = (state == SWEEP);
  assign sweep_addr = ptr;

endmodule

// File: rtl/kf_databank.sv
// Kalman filter working-state register bank: DEPTH x W, one write port
// (address shared with read port A) and two registered read ports.
// Ports: CLK, RST (async, active-high), bus (kf_databank_if.slave).
// Build option: KF_DATABANK_BYPASS_EN selects write-first reads on an
// address collision; when undefined the read ports return pre-write data.
module kf_databank
  import kf_pkg::*;
#(
  parameter int unsigned W     = KF_W,
  parameter int unsigned ADDRW = KF_ADDRW,
  parameter int unsigned DEPTH = 1 << ADDRW
) (
  input  logic            CLK,
  input  logic            RST,
  kf_databank_if.slave    bus
);

  localparam int unsigned AW1 = ADDRW + 1;

  logic [W-1:0]          mem [DEPTH];
  logic                  busy;
  logic                  sweep_we;
  logic [ADDRW-1:0]      sweep_addr;
  logic                  in_a;
  logic                  in_b;
  logic                  run_we;
  logic                  mem_we;
  logic [ADDRW-1:0]      mem_addr;
  logic [W-1:0]          mem_wdata;
  logic [W-1:0]          rd_a;
  logic [W-1:0]          rd_b;
  logic [W-1:0]          dout_a;
  logic [W-1:0]          dout_b;
  logic [KF_WRCNT_W-1:0] wr_cnt;

  kf_clear_seq #(
    .ADDRW (ADDRW),
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk        (CLK),
    .rst        (RST),
    .clear      (bus.CLEAR),
    .busy       (busy),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  // Addresses past DEPTH only exist when DEPTH < 2**ADDRW.
  assign in_a   = {1'b0, bus.db_dira} < AW1'(DEPTH);
  assign in_b   = {1'b0, bus.db_dirb} < AW1'(DEPTH);
  assign run_we = bus.db_write && in_a && !busy;

  // Sweep owns the write port while it runs; router writes are dropped.
  assign mem_we    = sweep_we || run_we;
  assign mem_addr  = sweep_we ? sweep_addr : bus.db_dira;
  assign mem_wdata = sweep_we ? '0 : bus.db_data;

  // Storage array, deliberately without reset; the sweep zeroes it.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Read-port A data, including collision handling with the write.
  always_comb begin
    rd_a = '0;
    if (in_a) begin
      rd_a = mem[bus.db_dira];
    end
`ifdef KF_DATABANK_BYPASS_EN
    if (run_we) begin
      rd_a = bus.db_data;
    end
`endif
  end

  // Read-port B data, bypassing only when its address matches the write.
  always_comb begin
    rd_b = '0;
    if (in_b) begin
      rd_b = mem[bus.db_dirb];
    end
`ifdef KF_DATABANK_BYPASS_EN
    if (run_we && (bus.db_dirb == bus.db_dira)) begin
      rd_b = bus.db_data;
    end
`endif
  end

  // Output registers and accepted-write counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout_a <= '0;
      dout_b <= '0;
      wr_cnt <= '0;
    end else begin
      if (busy) begin
        dout_a <= '0;
        dout_b <= '0;
      end else begin
        dout_a <= rd_a;
        dout_b <= rd_b;
        if (bus.CLEAR) begin
          wr_cnt <= '0;
        end else if (run_we) begin
          wr_cnt <= kf_sat_inc(wr_cnt);
        end
      end
    end
  end

  assign bus.DOUT_A = dout_a;
  assign bus.DOUT_B = dout_b;
  assign bus.BUSY   = busy;
  assign bus.WR_CNT = wr_cnt;

endmodule

// File: doc/kf_databank.md
# kf_databank

Storage stage directly downstream of the datapath address/data router. Holds the Kalman filter's working state (matrix and vector elements) as a DEPTH×W register bank with one write port and two independent read ports. Consumes the router's `db_data`/`db_dira`/`db_dirb`/`db_write` bus and returns two registered operands to the arithmetic unit. Includes a self-clearing sweep sequencer so the array needs no per-entry reset.

## Interface
- `W`, 24: data word width.
- `ADDRW`, 5: address width.
- `DEPTH`, 2**ADDRW (32): number of entries.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `db_data` in W: write data from the router.
- `db_dira` in ADDRW: read address, port A; also the write address.
- `db_dirb` in ADDRW: read address, port B.
- `db_write` in 1: write strobe, already gated by the router.
- `CLEAR` in 1: request a re-zero sweep of the whole bank.
- `DOUT_A` out W: registered read data, port A.
- `DOUT_B` out W: registered read data, port B.
- `BUSY` out 1: high while the sweep runs. Writes are ignored and reads return 0 while `BUSY` is high.
- `WR_CNT` out 16: saturating count of accepted writes since the last sweep finished.

## Operation
- FSM with two states: `SWEEP` and `RUN`.
- **Reset (`RST`=1, asynchronous):** state=`SWEEP`, sweep pointer=0, `DOUT_A`=`DOUT_B`=0, `BUSY`=1, `WR_CNT`=0. Array contents are not reset.
- **`SWEEP`:**
  - Each cycle writes 0 to entry[ptr], then increments ptr.
  - When ptr=DEPTH-1 is written, the next state is `RUN` and ptr wraps to 0.
  - `db_write` is ignored. `DOUT_A`/`DOUT_B` load 0.
  - `CLEAR` while already in `SWEEP` does not restart the sweep; it is ignored.
- **`RUN`:**
  - Write: when `db_write`=1, entry[`db_dira`] ← `db_data` at the clock edge, and `WR_CNT` increments, saturating at 16'hFFFF.
  - Read: `DOUT_A` ← entry[`db_dira`] and `DOUT_B` ← entry[`db_dirb`] every cycle, regardless of `db_write`.
  - `CLEAR`=1 sampled in `RUN`:
    - Next state is `SWEEP` with ptr=0 and `WR_CNT`←0.
    - A `db_write` in that same cycle is still performed, then cleared by the sweep.
- `db_dira`=`db_dirb` is legal; both ports return the same value.
- All addresses are in range when DEPTH=2**ADDRW. If DEPTH<2**ADDRW, writes to out-of-range addresses are dropped and reads from them return 0.

## Timing
- Read latency is 1 cycle: the address presented at edge N gives data on `DOUT_*` after edge N+1.
- A full sweep takes DEPTH cycles (32 by default).
  - `BUSY` falls on the edge that completes the write of entry DEPTH-1, i.e. 32 cycles after reset deassertion.
  - The first accepted write is in cycle 33.
- `CLEAR` to `BUSY` high: 1 cycle.
- `RST` asserted mid-sweep or mid-write: the sweep restarts from ptr=0 after `RST` deasserts. No partial write is guaranteed.
- Read-during-write to the same address on the same edge is governed by the configuration macro (see Configuration). Port B behaves identically to port A.

## Configuration
- `KF_DATABANK_BYPASS_EN`
  - **Defined:** write-first. If `db_write`=1 and a read address equals `db_dira`, that port's `DOUT` loads `db_data` on the same edge.
  - **Undefined:** read-first. That port's `DOUT` loads the pre-write contents, and the new value is visible on the following read.
  - In both builds, reads during `SWEEP` return 0.

## Structure
- Shared package `kf_pkg` holds:
  - `KF_W`=24 and `KF_ADDRW`=5.
  - `kf_db_state_t` enum {`SWEEP`, `RUN`}.
  - `KF_WRCNT_W`=16.
- One sub-module, `kf_clear_seq`, contains the FSM, sweep pointer and `BUSY`. It outputs `sweep_we` and `sweep_addr`, which are muxed into the write port by the top level.
- The array, read registers and bypass logic stay in `kf_databank`.

## Test plan
- **Reset/sweep:** pulse `RST`.
  - `BUSY`=1 for exactly 32 cycles, `DOUT_A`=`DOUT_B`=0 throughout.
  - `db_write` of 24'h123456 @5 during the sweep → a later read of addr 5 returns 0.
- **Write/read:** after the sweep, write 24'hC0FFEE @3 and 24'h123456 @28. Set `db_dira`=3, `db_dirb`=28.
  - Next cycle: `DOUT_A`=C0FFEE, `DOUT_B`=123456.
  - `WR_CNT`=2.
- **Same-address collision:** entry 18 holds 24'h000001. Write 24'hABCDEF @18 with `db_dirb`=18.
  - Bypass build: `DOUT_B`=ABCDEF.
  - Non-bypass build: `DOUT_B`=000001, then ABCDEF on the next cycle.
- **`CLEAR` with write:** in `RUN`, assert `CLEAR` together with a write of 24'h555555 @0.
  - `BUSY`=1 on the next cycle, `WR_CNT`=0.
  - After 32 cycles, a read of addr 0 returns 0.
- **Mid-sweep reset:** assert `RST` at sweep cycle 10.
  - After deassertion, `BUSY` stays high for a full 32 cycles.
  - A second `CLEAR` pulse during the sweep does not extend it.
